// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I core front end.
// Fetch FSM states, the SYSTEM opcode and instruction field positions.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int OP_LSB  = 0;
  localparam int OP_MSB  = 6;
  localparam int RD_LSB  = 7;
  localparam int RD_MSB  = 11;
  localparam int F3_LSB  = 12;
  localparam int F3_MSB  = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB  = 25;
  localparam int F7_MSB  = 31;

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: 32-bit words, synchronous write port
// for program loading, combinational read port for fetch.
module instr_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, run-control FSM, instruction memory, field slicing.
// Define PC_WRAP_EN to wrap to RESET_PC at end of memory instead of halting.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_wdata,
  input  logic          start,
  input  logic          stall,
  output logic [31:0]   pc,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic [6:0]    Op,
  output logic [2:0]    funct3,
  output logic [6:0]    funct7,
  output logic [4:0]    rs1,
  output logic [4:0]    rs2,
  output logic [4:0]    rd,
  output logic          halted
);

  localparam logic [AW-1:0] LAST_IDX = AW'(IMEM_DEPTH - 1);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         mem_we;
  logic         is_sys;
  logic         at_last;

  // Loading is only allowed while the core is not executing.
  assign mem_we = imem_we && !reset && (state_q != RUN);

  instr_mem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (imem_addr),
    .wdata (imem_wdata),
    .raddr (pc_q[AW+1:2]),
    .rdata (instr)
  );

  assign Op     = instr[OP_MSB:OP_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign funct3 = instr[F3_MSB:F3_LSB];
  assign rs1    = instr[RS1_MSB:RS1_LSB];
  assign rs2    = instr[RS2_MSB:RS2_LSB];
  assign funct7 = instr[F7_MSB:F7_LSB];

  assign is_sys  = (Op == OP_SYSTEM);
  assign at_last = (pc_q[AW+1:2] == LAST_IDX);

  assign pc          = pc_q;
  assign halted      = (state_q == HALT);
  assign instr_valid = (state_q == RUN) && !is_sys;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      RUN: begin
        if (!stall) begin
          if (is_sys) begin
            state_d = HALT;
          end else if (at_last) begin
`ifdef PC_WRAP_EN
            pc_d    = RESET_PC;
`else
            state_d = HALT;
`endif
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch (IMEM_DEPTH=4).
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, imem_we, start, stall;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] pc, instr;
  logic        instr_valid, halted;
  logic [6:0]  Op, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;

  instruction_fetch #(
    .IMEM_DEPTH (4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .start       (start),
    .stall       (stall),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .Op          (Op),
    .funct3      (funct3),
    .funct7      (funct7),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic        ci;
    logic [31:0] instr;
    logic        cf;
    logic [6:0]  f7;
    logic [4:0]  rs2;
    logic [4:0]  rs1;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [6:0]  op;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [31:0] P0  = 32'h002081B3;
  localparam logic [31:0] P1  = 32'h40208233;
  localparam logic [31:0] P2  = 32'h0020F2B3;
  localparam logic [31:0] P3  = 32'h00000073;
  localparam logic [31:0] ONES = 32'hFFFFFFFF;
  localparam logic [31:0] NOP = 32'h00000013;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".pc"}, pc, e.pc);
      chk({e.name, ".valid"}, 32'(instr_valid), 32'(e.valid));
      chk({e.name, ".halted"}, 32'(halted), 32'(e.halted));
      if (e.ci) chk({e.name, ".instr"}, instr, e.instr);
      if (e.cf) begin
        chk({e.name, ".op"}, 32'(Op), 32'(e.op));
        chk({e.name, ".rd"}, 32'(rd), 32'(e.rd));
        chk({e.name, ".rs1"}, 32'(rs1), 32'(e.rs1));
        chk({e.name, ".rs2"}, 32'(rs2), 32'(e.rs2));
        chk({e.name, ".f3"}, 32'(funct3), 32'(e.f3));
        chk({e.name, ".f7"}, 32'(funct7), 32'(e.f7));
      end
    end
  end

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic ex(input string n, input logic [31:0] p,
                    input logic v, input logic h,
                    input logic ci, input logic [31:0] i);
    exp_t e;
    e = '{n, p, v, h, ci, i, 1'b0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(e);
  endtask

  task automatic exf(input string n, input logic [31:0] p,
                     input logic v, input logic [31:0] i,
                     input logic [6:0] f7, input logic [4:0] r2,
                     input logic [4:0] r1, input logic [2:0] f3,
                     input logic [4:0] d, input logic [6:0] op);
    exp_t e;
    e = '{n, p, v, 1'b0, 1'b1, i, 1'b1, f7, r2, r1, f3, d, op};
    exp_q.push_back(e);
  endtask

  logic [31:0] prog [4];

  initial begin
    prog = '{P0, P1, P2, P3};
    reset = 1'b1; imem_we = 1'b0; start = 1'b0; stall = 1'b0;
    imem_addr = '0; imem_wdata = '0;

    sync(); ex("reset", 0, 0, 0, 0, 0);
    sync(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      imem_we = 1'b1; imem_addr = 2'(i); imem_wdata = prog[i];
      ex("load", 0, 0, 0, 0, 0);
      sync();
    end
    imem_we = 1'b0; start = 1'b1;
    exf("run0", 0, 1, P0, 7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33);
    sync(); start = 1'b0;
    exf("run4", 4, 1, P1, 7'h20, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33);
    sync(); stall = 1'b1; ex("stall1", 4, 1, 0, 1, P1);
    sync(); ex("stall2", 4, 1, 0, 1, P1);
    sync(); stall = 1'b0;
    exf("run8", 8, 1, P2, 7'h00, 5'd2, 5'd1, 3'd7, 5'd5, 7'h33);
    sync();
    exf("sys", 12, 0, P3, 7'h00, 5'd0, 5'd0, 3'd0, 5'd0, 7'h73);
    sync(); ex("halt", 12, 0, 1, 1, P3);
    sync(); ex("halt_hold", 12, 0, 1, 1, P3);

    sync(); start = 1'b1; ex("restart", 0, 1, 0, 1, P0);
    sync(); start = 1'b0;
    imem_we = 1'b1; imem_addr = 2'd1; imem_wdata = ONES;
    ex("blk_wr", 4, 1, 0, 1, P1);
    sync(); imem_we = 1'b0; ex("pc8", 8, 1, 0, 1, P2);
    sync(); reset = 1'b1; ex("rst_mid", 0, 0, 0, 1, P0);
    sync(); reset = 1'b0; start = 1'b1; ex("refetch", 0, 1, 0, 1, P0);
    sync(); start = 1'b0; ex("re4", 4, 1, 0, 1, P1);
    sync(); ex("re8", 8, 1, 0, 1, P2);
    sync(); ex("re12", 12, 0, 0, 1, P3);
    sync(); ex("re_halt", 12, 0, 1, 1, P3);

    sync(); imem_we = 1'b1; imem_addr = 2'd1; imem_wdata = ONES;
    ex("hwr", 12, 0, 1, 1, P3);
    sync(); imem_we = 1'b1; imem_addr = 2'd3; imem_wdata = NOP;
    start = 1'b1; ex("wr_start", 0, 1, 0, 1, P0);
    sync(); imem_we = 1'b0; start = 1'b0;
    ex("wr_seen", 4, 1, 0, 1, ONES);
    sync(); ex("eom8", 8, 1, 0, 1, P2);
    sync(); ex("eom12", 12, 1, 0, 1, NOP);
`ifdef PC_WRAP_EN
    sync(); ex("wrap0", 0, 1, 0, 1, P0);
    sync(); ex("wrap4", 4, 1, 0, 1, ONES);
`else
    sync(); ex("eom_halt", 12, 0, 1, 1, NOP);
    sync(); ex("eom_hold", 12, 0, 1, 1, NOP);
`endif
    sync();
    sync();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
